// File: rtl/pcie_rx_deframer.sv
// Receive-side symbol deframer: acquires COM lock, tracks link idle, and strips
// STP/END framing from payload bytes with registered outputs.
module pcie_rx_deframer #(
  parameter int SYNC_COUNT = 4,
  parameter int MAX_LEN    = 16
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_k,
  input  logic       rx_valid,
  output logic [7:0] DATA,
  output logic       Valid,
  output logic [3:0] CONTROL,
  output logic       link_up,
  output logic       frame_done,
  output logic [4:0] frame_len,
  output logic       err_frame
);

  localparam logic [7:0] K_COM = 8'hBC;
  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_IDL = 8'h7C;
  localparam int         SC_W  = (SYNC_COUNT > 1) ? $clog2(SYNC_COUNT + 1) : 1;

  typedef enum logic [3:0] {
    ST_DETECT  = 4'd0,
    ST_ALIGN   = 4'd1,
    ST_IDLE    = 4'd2,
    ST_PAYLOAD = 4'd9
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [SC_W-1:0] r_sync, w_sync_nxt;
  logic [4:0]      r_len, w_len_nxt;
  logic [7:0]      r_data, w_data_nxt;
  logic [4:0]      r_flen, w_flen_nxt;
  logic            r_valid, w_valid_nxt;
  logic            r_done, w_done_nxt;
  logic            r_err, w_err_nxt;

  logic w_is_com, w_is_stp, w_is_end, w_is_idl;
  assign w_is_com = rx_k && (rx_data == K_COM);
  assign w_is_stp = rx_k && (rx_data == K_STP);
  assign w_is_end = rx_k && (rx_data == K_END);
  assign w_is_idl = rx_k && (rx_data == K_IDL);

  always_comb begin
    w_state_nxt = r_state;
    w_sync_nxt  = r_sync;
    w_len_nxt   = r_len;
    w_data_nxt  = r_data;
    w_flen_nxt  = r_flen;
    w_valid_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    if (rx_valid) begin
      case (r_state)
        ST_DETECT: begin
          if (!w_is_com) begin
            w_sync_nxt = '0;
          end else if (r_sync == SC_W'(SYNC_COUNT - 1)) begin
            w_state_nxt = ST_ALIGN;
            w_sync_nxt  = '0;
          end else begin
            w_sync_nxt = r_sync + SC_W'(1);
          end
        end
        ST_ALIGN: begin
          if (w_is_idl)      w_state_nxt = ST_IDLE;
          else if (!w_is_com) w_state_nxt = ST_DETECT;
        end
        ST_IDLE: begin
          if (!rx_k) begin
            w_err_nxt = 1'b1;
          end else if (w_is_stp) begin
            w_state_nxt = ST_PAYLOAD;
            w_len_nxt   = '0;
          end else if (!w_is_com && !w_is_idl) begin
            // END or an unknown K while idle means lock is suspect: resync.
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_DETECT;
          end
        end
        ST_PAYLOAD: begin
          if (!rx_k) begin
            if (r_len < 5'(MAX_LEN)) begin
              w_data_nxt  = rx_data;
              w_valid_nxt = 1'b1;
              w_len_nxt   = r_len + 5'd1;
            end else begin
              w_err_nxt   = 1'b1;
              w_state_nxt = ST_IDLE;
            end
          end else if (w_is_end && (r_len != 5'd0)) begin
            w_done_nxt  = 1'b1;
            w_flen_nxt  = r_len;
            w_state_nxt = ST_IDLE;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_DETECT;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state <= ST_DETECT;
      r_sync  <= '0;
      r_len   <= '0;
      r_data  <= '0;
      r_flen  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sync  <= w_sync_nxt;
      r_len   <= w_len_nxt;
      r_data  <= w_data_nxt;
      r_flen  <= w_flen_nxt;
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign DATA       = r_data;
  assign Valid      = r_valid;
  assign CONTROL    = r_state;
  assign link_up    = (r_state == ST_IDLE) || (r_state == ST_PAYLOAD);
  assign frame_done = r_done;
  assign frame_len  = r_flen;
  assign err_frame  = r_err;

endmodule

// File: tb/tb_pcie_rx_deframer.sv
// Bench for pcie_rx_deframer: directed scenarios plus randomized symbol streams
// compared against a queue-based framing model.
module tb_pcie_rx_deframer;

  localparam int SYNC = 4;
  localparam int MAXL = 16;
  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] STP = 8'hFB;
  localparam logic [7:0] ENDK = 8'hFD;
  localparam logic [7:0] IDL = 8'h7C;
  localparam logic [7:0] BADK = 8'h1C;

  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_k = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] DATA;
  logic       Valid;
  logic [3:0] CONTROL;
  logic       link_up;
  logic       frame_done;
  logic [4:0] frame_len;
  logic       err_frame;

  int n_checks = 0;
  int n_errors = 0;

  pcie_rx_deframer #(.SYNC_COUNT(SYNC), .MAX_LEN(MAXL)) dut (
    .CLK(CLK), .reset(reset), .rx_data(rx_data), .rx_k(rx_k), .rx_valid(rx_valid),
    .DATA(DATA), .Valid(Valid), .CONTROL(CONTROL), .link_up(link_up),
    .frame_done(frame_done), .frame_len(frame_len), .err_frame(err_frame)
  );

  always #5 CLK = ~CLK;

  // Reference model: link mode, COM run length, and the current frame as a byte queue.
  int         m_mode = 0;
  int         m_coms = 0;
  logic [7:0] m_frame[$];
  logic [7:0] e_data = 8'h00;
  logic [4:0] e_flen = 5'd0;
  logic       e_valid = 1'b0, e_done = 1'b0, e_err = 1'b0, e_link = 1'b0;
  logic [3:0] e_ctrl = 4'd0;

  task automatic model_step(input bit rst, input bit v, input bit k, input logic [7:0] d);
    e_valid = 1'b0; e_done = 1'b0; e_err = 1'b0;
    if (rst) begin
      m_mode = 0; m_coms = 0; m_frame.delete();
      e_data = 8'h00; e_flen = 5'd0;
    end else if (v) begin
      case (m_mode)
        0: begin
          if (k && d == COM) begin
            m_coms++;
            if (m_coms == SYNC) begin m_mode = 1; m_coms = 0; end
          end else m_coms = 0;
        end
        1: begin
          if (k && d == IDL) m_mode = 2;
          else if (!(k && d == COM)) m_mode = 0;
        end
        2: begin
          if (!k) e_err = 1'b1;
          else if (d == STP) begin m_mode = 9; m_frame.delete(); end
          else if (d != COM && d != IDL) begin e_err = 1'b1; m_mode = 0; end
        end
        default: begin
          if (!k) begin
            if (m_frame.size() < MAXL) begin
              m_frame.push_back(d); e_data = d; e_valid = 1'b1;
            end else begin e_err = 1'b1; m_mode = 2; end
          end else if (d == ENDK && m_frame.size() > 0) begin
            e_done = 1'b1; e_flen = 5'(m_frame.size()); m_mode = 2;
          end else begin e_err = 1'b1; m_mode = 2; end
        end
      endcase
    end
    e_ctrl = 4'(m_mode);
    e_link = (m_mode == 2) || (m_mode == 9);
  endtask

  task automatic send(input bit rst, input bit v, input bit k, input logic [7:0] d);
    reset = rst; rx_valid = v; rx_k = k; rx_data = d;
    model_step(rst, v, k, d);
    @(posedge CLK);
    #1;
  endtask

  task automatic bringup();
    send(1, 0, 0, 8'h00);
    for (int i = 0; i < SYNC; i++) send(0, 1, 1, COM);
    send(0, 1, 1, IDL);
  endtask

  task automatic test_reset();
    send(1, 1, 1, COM);
    send(1, 1, 0, 8'h55);
    n_checks++;
    if ({DATA, Valid, CONTROL, link_up, frame_done, frame_len, err_frame} !== 21'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got DATA=%h V=%b CTRL=%0d LU=%b FD=%b FL=%0d ERR=%b, want all 0",
               DATA, Valid, CONTROL, link_up, frame_done, frame_len, err_frame);
    end
  endtask

  task automatic test_bringup();
    logic [3:0] want[5] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2};
    send(1, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      send(0, 1, 1, (i < 4) ? COM : IDL);
      n_checks++;
      if (CONTROL !== want[i]) begin
        n_errors++;
        $display("FAIL bringup_ctrl[%0d]: got %0d want %0d", i, CONTROL, want[i]);
      end
    end
    n_checks++;
    if (link_up !== 1'b1) begin
      n_errors++;
      $display("FAIL bringup_link_up: got %b want 1", link_up);
    end
  endtask

  task automatic test_good_frame();
    logic [7:0] bytes[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send(0, 1, 1, STP);
    for (int i = 0; i < 4; i++) begin
      send(0, 1, 0, bytes[i]);
      n_checks++;
      if (Valid !== 1'b1 || DATA !== bytes[i] || CONTROL !== 4'd9) begin
        n_errors++;
        $display("FAIL good_byte[%0d]: got V=%b DATA=%h CTRL=%0d want V=1 DATA=%h CTRL=9",
                 i, Valid, DATA, CONTROL, bytes[i]);
      end
    end
    send(0, 1, 1, ENDK);
    n_checks++;
    if (frame_done !== 1'b1 || frame_len !== 5'd4 || CONTROL !== 4'd2 || err_frame !== 1'b0) begin
      n_errors++;
      $display("FAIL good_end: got FD=%b FL=%0d CTRL=%0d ERR=%b want FD=1 FL=4 CTRL=2 ERR=0",
               frame_done, frame_len, CONTROL, err_frame);
    end
  endtask

  task automatic test_sync_break();
    send(1, 0, 0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      send(0, 1, (i != 3), (i == 3) ? 8'h4F : COM);
      n_checks++;
      if (CONTROL !== ((i == 7) ? 4'd1 : 4'd0)) begin
        n_errors++;
        $display("FAIL sync_break[%0d]: got CTRL=%0d want %0d", i, CONTROL, (i == 7) ? 1 : 0);
      end
    end
    send(0, 1, 0, 8'h00);
    n_checks++;
    if (CONTROL !== 4'd0 || err_frame !== 1'b0) begin
      n_errors++;
      $display("FAIL align_drop: got CTRL=%0d ERR=%b want CTRL=0 ERR=0", CONTROL, err_frame);
    end
  endtask

  task automatic test_overflow();
    int pulses = 0;
    bringup();
    send(0, 1, 1, STP);
    for (int i = 0; i < 17; i++) begin
      send(0, 1, 0, 8'(i + 1));
      if (Valid === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 16) begin
      n_errors++;
      $display("FAIL overflow_pulses: got %0d want 16", pulses);
    end
    n_checks++;
    if (err_frame !== 1'b1 || CONTROL !== 4'd2 || frame_done !== 1'b0 || Valid !== 1'b0) begin
      n_errors++;
      $display("FAIL overflow_end: got ERR=%b CTRL=%0d FD=%b V=%b want ERR=1 CTRL=2 FD=0 V=0",
               err_frame, CONTROL, frame_done, Valid);
    end
  endtask

  task automatic test_errors();
    logic [4:0] old_len;
    send(0, 1, 1, STP);
    send(0, 1, 0, 8'h01);
    send(0, 1, 0, 8'h02);
    send(0, 1, 1, ENDK);
    old_len = frame_len;
    send(0, 1, 1, STP);
    send(0, 1, 1, ENDK);
    n_checks++;
    if (err_frame !== 1'b1 || frame_done !== 1'b0 || frame_len !== 5'd2 || old_len !== 5'd2) begin
      n_errors++;
      $display("FAIL empty_frame: got ERR=%b FD=%b FL=%0d want ERR=1 FD=0 FL=2",
               err_frame, frame_done, frame_len);
    end
    send(0, 1, 1, STP);
    send(0, 1, 0, 8'hAA);
    n_checks++;
    if (Valid !== 1'b1 || DATA !== 8'hAA) begin
      n_errors++;
      $display("FAIL abort_byte: got V=%b DATA=%h want V=1 DATA=aa", Valid, DATA);
    end
    send(0, 1, 1, COM);
    n_checks++;
    if (err_frame !== 1'b1 || Valid !== 1'b0 || CONTROL !== 4'd2 || DATA !== 8'hAA) begin
      n_errors++;
      $display("FAIL abort_com: got ERR=%b V=%b CTRL=%0d DATA=%h want ERR=1 V=0 CTRL=2 DATA=aa",
               err_frame, Valid, CONTROL, DATA);
    end
    send(0, 1, 0, 8'h33);
    n_checks++;
    if (err_frame !== 1'b1 || Valid !== 1'b0 || CONTROL !== 4'd2) begin
      n_errors++;
      $display("FAIL idle_data: got ERR=%b V=%b CTRL=%0d want ERR=1 V=0 CTRL=2", err_frame, Valid, CONTROL);
    end
    send(0, 1, 1, ENDK);
    n_checks++;
    if (err_frame !== 1'b1 || CONTROL !== 4'd0 || link_up !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_end: got ERR=%b CTRL=%0d LU=%b want ERR=1 CTRL=0 LU=0", err_frame, CONTROL, link_up);
    end
  endtask

  task automatic test_gaps();
    logic [7:0] bytes[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [7:0] got[$];
    bit bad_gap = 0;
    bit saw_done = 0;
    bringup();
    send(0, 1, 1, STP);
    for (int i = 0; i <= 5; i++) begin
      int gaps = $urandom_range(3, 1);
      for (int g = 0; g < gaps; g++) begin
        send(0, 0, 1'($urandom), 8'($urandom));
        if (Valid !== 1'b0 || CONTROL !== 4'd9 || err_frame !== 1'b0 || frame_done !== 1'b0 ||
            (i > 0 && DATA !== bytes[i-1])) bad_gap = 1;
      end
      if (i < 5) send(0, 1, 0, bytes[i]);
      else send(0, 1, 1, ENDK);
      if (Valid === 1'b1) got.push_back(DATA);
      if (frame_done === 1'b1 && frame_len === 5'd5) saw_done = 1;
    end
    n_checks++;
    if (bad_gap) begin
      n_errors++;
      $display("FAIL gap_idle: got activity during rx_valid=0 want none");
    end
    n_checks++;
    if (got.size() != 5 || got[0] !== 8'h11 || got[4] !== 8'h55 || got[2] !== 8'h33 || !saw_done) begin
      n_errors++;
      $display("FAIL gap_sequence: got %0d bytes done=%b want 5 bytes 11..55 done=1", got.size(), saw_done);
    end
    send(0, 1, 1, STP);
    send(0, 1, 0, 8'h12);
    send(0, 1, 0, 8'h34);
    send(1, 1, 1, ENDK);
    n_checks++;
    if ({DATA, Valid, CONTROL, link_up, frame_done, frame_len, err_frame} !== 21'd0) begin
      n_errors++;
      $display("FAIL reset_mid_frame: got DATA=%h V=%b CTRL=%0d LU=%b FD=%b FL=%0d ERR=%b want all 0",
               DATA, Valid, CONTROL, link_up, frame_done, frame_len, err_frame);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    int both = 0;
    for (int ep = 0; ep < 25; ep++) begin
      send(1, 0, 0, 8'h00);
      for (int i = 0; i < SYNC + 1; i++) begin
        while ($urandom_range(3, 0) == 0) send(0, 0, 1'($urandom), 8'($urandom));
        send(0, 1, 1, (i < SYNC) ? COM : IDL);
      end
      for (int s = 0; s < 40; s++) begin
        int r = $urandom_range(99, 0);
        bit v = ($urandom_range(9, 0) < 8);
        bit rst = ($urandom_range(99, 0) == 0);
        if (r < 50)      send(rst, v, 0, 8'($urandom));
        else if (r < 64) send(rst, v, 1, STP);
        else if (r < 80) send(rst, v, 1, ENDK);
        else if (r < 87) send(rst, v, 1, COM);
        else if (r < 95) send(rst, v, 1, IDL);
        else             send(rst, v, 1, BADK);
        n_checks++;
        if ({CONTROL, link_up, Valid, DATA, frame_done, frame_len, err_frame} !==
            {e_ctrl, e_link, e_valid, e_data, e_done, e_flen, e_err}) begin
          n_errors++;
          bad++;
          if (bad <= 5)
            $display("FAIL random[%0d.%0d]: got CTRL=%0d LU=%b V=%b D=%h FD=%b FL=%0d ERR=%b want CTRL=%0d LU=%b V=%b D=%h FD=%b FL=%0d ERR=%b",
                     ep, s, CONTROL, link_up, Valid, DATA, frame_done, frame_len, err_frame,
                     e_ctrl, e_link, e_valid, e_data, e_done, e_flen, e_err);
        end
        if (frame_done === 1'b1 && err_frame === 1'b1) both++;
      end
    end
    n_checks++;
    if (both != 0) begin
      n_errors++;
      $display("FAIL done_err_exclusive: got %0d overlapping cycles want 0", both);
    end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_good_frame();
    test_sync_break();
    test_overflow();
    test_errors();
    test_gaps();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
